// File: rtl/lut_wvf_sequencer.sv
// lut_wvf_sequencer: steps one LUT_WVF_GEN generator through a 4-entry
// (WAIT_CYC, period count) profile table, with an idle gap between profiles.
// Optional feature macro: LUT_SEQ_LOOP_EN adds a LOOP input that restarts the
// sequence at profile 0 instead of finishing with DONE.
//
// Interface protocol: there is no valid/ready pairing here. START, STOP and
// CFG_WE are single-cycle strobes sampled on the rising edge of CLK_SYS and
// are always accepted (START is dropped while BUSY, STOP beats START).
// LUT_END is a one-cycle pulse from the generator and only counts in RUN.
// DBG_STATE exposes the FSM state for checkers.
module lut_wvf_sequencer #(
    parameter int CNT_WIDTH = 16,
    parameter int PER_WIDTH = 8,
    parameter int GAP_CYC   = 4
) (
    input  logic                 CLK_SYS,
    input  logic                 RST,
    input  logic                 CFG_WE,
    input  logic [1:0]           CFG_ADDR,
    input  logic [CNT_WIDTH-1:0] CFG_WAIT,
    input  logic [PER_WIDTH-1:0] CFG_NPER,
    input  logic [1:0]           CFG_LAST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 LUT_END,
`ifdef LUT_SEQ_LOOP_EN
    input  logic                 LOOP,
`endif
    output logic                 LUT_EN,
    output logic [CNT_WIDTH-1:0] LUT_WAIT_CYC,
    output logic [1:0]           PROF_IDX,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2:0]           DBG_STATE
);

    // Gap counter needs at least one bit even when the gap is disabled.
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [1:0]           idx;
    logic [1:0]           last_q;
    logic [PER_WIDTH-1:0] target;
    logic [PER_WIDTH-1:0] per_cnt;
    logic [PER_WIDTH-1:0] per_cnt_inc;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CNT_WIDTH-1:0] wait_tbl [4];
    logic [PER_WIDTH-1:0] nper_tbl [4];
    logic                 loop_req;

`ifdef LUT_SEQ_LOOP_EN
    assign loop_req = LOOP;
`else
    assign loop_req = 1'b0;
`endif

    assign per_cnt_inc = per_cnt + PER_WIDTH'(1);

    // Profile table: writable at any time, read only in LOAD.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                wait_tbl[i] <= '0;
                nper_tbl[i] <= '0;
            end
        end else if (CFG_WE) begin
            wait_tbl[CFG_ADDR] <= CFG_WAIT;
            nper_tbl[CFG_ADDR] <= CFG_NPER;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; STOP overrides everything outside IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (START && !STOP) next_state = S_LOAD;
            S_LOAD: next_state = (nper_tbl[idx] == '0) ? S_NEXT : S_RUN;
            S_RUN: begin
                if (LUT_END && (per_cnt_inc == target)) begin
                    next_state = (GAP_CYC == 0) ? S_NEXT : S_GAP;
                end
            end
            S_GAP:  if (gap_cnt == GAP_LAST) next_state = S_NEXT;
            S_NEXT: begin
                if (idx == last_q) begin
                    next_state = loop_req ? S_LOAD : S_DONE;
                end else begin
                    next_state = S_LOAD;
                end
            end
            S_DONE: next_state = START ? S_LOAD : S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (STOP && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end
    end

    // Datapath: profile index, latched profile values, counters and LUT_EN.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            LUT_EN       <= 1'b0;
            LUT_WAIT_CYC <= '0;
            idx          <= '0;
            last_q       <= '0;
            target       <= '0;
            per_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            // LUT_EN is high exactly while the FSM sits in RUN.
            LUT_EN <= (next_state == S_RUN);

            if (((state == S_IDLE) || (state == S_DONE)) && (next_state == S_LOAD)) begin
                idx    <= '0;
                last_q <= CFG_LAST;
            end

            if ((state == S_NEXT) && (next_state == S_LOAD)) begin
                idx <= (idx == last_q) ? 2'd0 : idx + 2'd1;
            end

            if (state == S_LOAD) begin
                LUT_WAIT_CYC <= wait_tbl[idx];
                target       <= nper_tbl[idx];
                per_cnt      <= '0;
            end

            // The compare ends RUN at per_cnt_inc == target, so no wrap.
            if ((state == S_RUN) && LUT_END) begin
                per_cnt <= per_cnt_inc;
            end

            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    assign PROF_IDX  = idx;
    assign BUSY      = (state != S_IDLE) && (state != S_DONE);
    assign DONE      = (state == S_DONE);
    assign DBG_STATE = state;

endmodule
